regfile_dump_ctrl: RTL and testbench
====================================

# regfile_dump_ctrl

Hardware register-file dump engine that sits beside `pipelined_datapath`. On request it freezes the core and reads every architectural register through a dedicated debug read port. Each register is serialised into OUT_W-bit chunks on a valid/ready byte stream that feeds the board debug path (UART bridge or `reg_out` LEDs). It is parametrised in register count, register width and output width. It adds single-step and abort modes.

## Interface
- `NREGS`, 32: number of registers scanned, indices 0..NREGS-1.
- `XLEN`, 32: register width; must be a multiple of OUT_W.
- `OUT_W`, 8: stream chunk width.
- `SKIP_X0`, 0: if 1, index 0 is not emitted.

- `clk`  in  1  system clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a dump; ignored unless IDLE.
- `mode`  in  1  sampled with `start`: 0 = stream, 1 = step.
- `step`  in  1  one-cycle pulse that releases the next chunk in step mode.
- `abort`  in  1  returns to IDLE from any state.
- `halt_req`  out  1  freeze request to the core.
- `halt_ack`  in  1  core confirms it is frozen.
- `rf_rd_addr`  out  $clog2(NREGS)  debug read index.
- `rf_rd_data`  in  XLEN  combinational read data for `rf_rd_addr`.
- `out_valid`  out  1  chunk available.
- `out_ready`  in  1  sink accepts the chunk.
- `out_data`  out  OUT_W  chunk, most-significant chunk first.
- `out_idx`  out  $clog2(NREGS)  register index of the current chunk.
- `out_last`  out  1  final chunk of the final register.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States:
  - IDLE: wait for `start`. On `start`, latch `mode`, set the index to 0 (or 1 if SKIP_X0), go to HALT.
  - HALT: hold `halt_req`=1. When `halt_ack`=1, go to LOAD. Wait indefinitely otherwise.
  - LOAD: capture `rf_rd_data` into the shift register, set the chunk counter to CHUNKS-1, go to SEND. In step mode go to WAIT_STEP instead.
  - WAIT_STEP: `out_valid`=0. On `step`, go to SEND.
  - SEND: `out_valid`=1. On `out_valid && out_ready`:
    - Not the last chunk: shift left by OUT_W and decrement the counter. Step mode goes to WAIT_STEP; stream mode stays in SEND.
    - Last chunk of a register that is not the last: increment the index, go to LOAD.
    - Last chunk of the last register: go to DONE.
  - DONE: drop `halt_req`, go to IDLE.
- CHUNKS = XLEN/OUT_W.
- `out_data` = shift register [XLEN-1 -: OUT_W].
- `out_last` = (index == NREGS-1) && (chunk counter == 0) && SEND.
- `halt_req` is high in HALT, LOAD, WAIT_STEP and SEND.
- `rf_rd_addr` always equals the registered index.
- `halt_ack` is sampled only in HALT. A later drop of `halt_ack` is ignored.
- `abort` has priority over every transition. The next state is IDLE, and `halt_req`, `out_valid` and `busy` all clear on the following edge. A chunk accepted in the same cycle as `abort` counts as delivered.
- `start` while busy is ignored. `step` outside WAIT_STEP is ignored. `step` and `abort` together resolve to abort.
- Stability: while `out_valid && !out_ready`, `out_data`, `out_idx` and `out_last` must not change (abort excepted).

## Timing
- Reset values:
  - state IDLE
  - `halt_req`=0, `out_valid`=0, `out_last`=0, `busy`=0
  - `out_data`=0, `out_idx`=0, `rf_rd_addr`=0
- `start` at edge N: `busy` and `halt_req` are high after edge N+1.
- `halt_ack` seen in HALT at edge M: LOAD at M+1, first `out_valid` at M+2. In step mode the first chunk appears on the edge after the first `step`.
- Stream mode with `out_ready` held at 1: one chunk per cycle within a register, plus one LOAD bubble per register. Total = CHUNKS·NREGS + NREGS cycles after HALT. The default configuration gives 160 cycles.
- `rf_rd_data` must settle within the cycle that `rf_rd_addr` is presented.
- Reset asserted mid-dump: immediate return to reset values, with no partial completion.

## Structure
- Package `dbg_pkg`:
  - state enum (IDLE, HALT, LOAD, WAIT_STEP, SEND, DONE)
  - mode constants MODE_STREAM=0, MODE_STEP=1
  - CHUNKS derivation helper
- Sub-module `dump_serializer`: parallel load, shift by OUT_W, chunk counter, and the `last_chunk` flag, parametrised by XLEN/OUT_W.
- Top level holds only the FSM and the index counter.
- Elaboration check: XLEN % OUT_W == 0.

## Test plan
- Stream, defaults, x1=0xDEADBEEF, `halt_ack` tied high, `out_ready`=1 → chunks for idx 1 are DE, AD, BE, EF; 128 chunks total; `out_last` only on idx 31 chunk 0; `halt_req` falls one cycle later.
- Backpressure: toggle `out_ready` at random → `out_data` stays stable while stalled; no chunk is duplicated or dropped; sequence identical to the previous test.
- Step mode, x2=0x12345678 → exactly one chunk per `step` pulse, in order 12, 34, 56, 78; no `out_valid` without a preceding `step`.
- Delay `halt_ack` by 10 cycles → no `out_valid` before the ack; `rf_rd_addr` is held at 0.
- `abort` during idx 5 chunk 2, and separately `resetn` low mid-dump → IDLE with all outputs at reset values next cycle; a new `start` dumps from idx 0.
- SKIP_X0=1, NREGS=4, OUT_W=16 → 6 chunks, idx sequence 1,1,2,2,3,3; `start` while busy is ignored.

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared state encoding, mode constants and sizing helpers for the register-file dump engine.
package dbg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    LOAD,
    WAIT_STEP,
    SEND,
    DONE
  } dump_state_t;

  localparam logic MODE_STREAM = 1'b0;
  localparam logic MODE_STEP   = 1'b1;

  function automatic int calc_chunks(input int xlen, input int out_w);
    return xlen / out_w;
  endfunction

  // Counter width that stays legal when only one value is needed.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dump_serializer.sv
// Splits one register value into OUT_W-bit chunks, most-significant chunk first.
// Parallel load, shift-left per accepted chunk, and a down-counter flagging the final chunk.
module dump_serializer
  import dbg_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic [XLEN-1:0]  load_data,
  output logic [OUT_W-1:0] chunk,
  output logic             last_chunk
);

  localparam int CHUNKS = calc_chunks(XLEN, OUT_W);
  localparam int CW     = cnt_width(CHUNKS);

  logic [XLEN-1:0] shreg;
  logic [CW-1:0]   cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (clr) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= load_data;
      cnt   <= CW'(CHUNKS - 1);
    end else if (shift) begin
      shreg <= shreg << OUT_W;
      cnt   <= cnt - CW'(1);
    end
  end

  assign chunk      = shreg[XLEN-1 -: OUT_W];
  assign last_chunk = (cnt == '0);

endmodule

// File: rtl/regfile_dump_ctrl.sv
// Freezes the core, reads each architectural register over the debug port and streams it out
// in OUT_W-bit chunks on a valid/ready interface, either free-running or one chunk per step pulse.
module regfile_dump_ctrl
  import dbg_pkg::*;
#(
  parameter int NREGS   = 32,
  parameter int XLEN    = 32,
  parameter int OUT_W   = 8,
  parameter int SKIP_X0 = 0
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic                     mode,
  input  logic                     step,
  input  logic                     abort,
  output logic                     halt_req,
  input  logic                     halt_ack,
  output logic [$clog2(NREGS)-1:0] rf_rd_addr,
  input  logic [XLEN-1:0]          rf_rd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic [$clog2(NREGS)-1:0] out_idx,
  output logic                     out_last,
  output logic                     busy
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] FIRST_IDX = (SKIP_X0 != 0) ? AW'(1) : AW'(0);
  localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);

  if (XLEN % OUT_W != 0) begin : g_bad_width
    $error("regfile_dump_ctrl: XLEN must be a multiple of OUT_W");
  end

  dump_state_t   state;
  logic          mode_q;
  logic [AW-1:0] idx;
  logic          last_chunk;
  logic          ser_load;
  logic          ser_shift;
  logic          accept;

  assign accept    = out_valid && out_ready;
  assign ser_load  = (state == LOAD) && !abort;
  assign ser_shift = accept && !last_chunk && !abort;

  dump_serializer #(
    .XLEN  (XLEN),
    .OUT_W (OUT_W)
  ) u_ser (
    .clk        (clk),
    .resetn     (resetn),
    .clr        (abort),
    .load       (ser_load),
    .shift      (ser_shift),
    .load_data  (rf_rd_data),
    .chunk      (out_data),
    .last_chunk (last_chunk)
  );

  // Output flags are registered alongside the state so they change on the same edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      mode_q    <= MODE_STREAM;
      idx       <= '0;
      halt_req  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      idx       <= '0;
      halt_req  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_q   <= mode;
            idx      <= FIRST_IDX;
            state    <= HALT;
            halt_req <= 1'b1;
            busy     <= 1'b1;
          end
        end
        HALT: begin
          if (halt_ack) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          if (mode_q == MODE_STEP) begin
            state <= WAIT_STEP;
          end else begin
            state     <= SEND;
            out_valid <= 1'b1;
          end
        end
        WAIT_STEP: begin
          if (step) begin
            state     <= SEND;
            out_valid <= 1'b1;
          end
        end
        SEND: begin
          if (accept) begin
            if (!last_chunk) begin
              if (mode_q == MODE_STEP) begin
                state     <= WAIT_STEP;
                out_valid <= 1'b0;
              end
            end else if (idx == LAST_IDX) begin
              state     <= DONE;
              out_valid <= 1'b0;
              halt_req  <= 1'b0;
            end else begin
              idx       <= idx + AW'(1);
              state     <= LOAD;
              out_valid <= 1'b0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          halt_req  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign rf_rd_addr = idx;
  assign out_idx    = idx;
  assign out_last   = out_valid && last_chunk && (idx == LAST_IDX);

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Bench for regfile_dump_ctrl: default configuration plus a SKIP_X0/NREGS=4/OUT_W=16 instance.
module tb_regfile_dump_ctrl;

  localparam int NREGS  = 32;
  localparam int CHUNKS = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  logic        start, mode, step, abort, halt_ack, out_ready;
  logic        halt_req, out_valid, out_last, busy;
  logic [4:0]  rf_rd_addr, out_idx;
  logic [31:0] rf_rd_data;
  logic [7:0]  out_data;

  logic        start2, mode2, step2, abort2, halt_ack2, out_ready2;
  logic        halt_req2, out_valid2, out_last2, busy2;
  logic [1:0]  rf_rd_addr2, out_idx2;
  logic [31:0] rf_rd_data2;
  logic [15:0] out_data2;

  logic [31:0] rf  [32];
  logic [31:0] rf2 [4];

  assign rf_rd_data  = rf[rf_rd_addr];
  assign rf_rd_data2 = rf2[rf_rd_addr2];

  always #5 clk = ~clk;

  regfile_dump_ctrl dut (
    .clk(clk), .resetn(resetn), .start(start), .mode(mode), .step(step), .abort(abort),
    .halt_req(halt_req), .halt_ack(halt_ack), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .busy(busy)
  );

  regfile_dump_ctrl #(.NREGS(4), .XLEN(32), .OUT_W(16), .SKIP_X0(1)) dut2 (
    .clk(clk), .resetn(resetn), .start(start2), .mode(mode2), .step(step2), .abort(abort2),
    .halt_req(halt_req2), .halt_ack(halt_ack2), .rf_rd_addr(rf_rd_addr2), .rf_rd_data(rf_rd_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_idx(out_idx2),
    .out_last(out_last2), .busy(busy2)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [21:0] snap1();
    return {busy, halt_req, out_valid, out_last, out_idx, rf_rd_addr, out_data};
  endfunction

  function automatic logic [23:0] snap2();
    return {busy2, halt_req2, out_valid2, out_last2, out_idx2, rf_rd_addr2, out_data2};
  endfunction

  typedef struct {
    logic       start, mode, step, ack, rdy, abrt;
    logic       e_busy, e_halt, e_valid;
    logic [4:0] e_idx;
    logic [7:0] e_data;
    logic       chk_data;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic s, m, st, a, r, ab,
                              input logic eb, eh, ev, input logic [4:0] ei,
                              input logic [7:0] ed, input logic cd);
    vec_t v;
    v.start = s; v.mode = m; v.step = st; v.ack = a; v.rdy = r; v.abrt = ab;
    v.e_busy = eb; v.e_halt = eh; v.e_valid = ev; v.e_idx = ei; v.e_data = ed; v.chk_data = cd;
    tbl.push_back(v);
  endfunction

  // Full stream-mode dump on the default instance, checked chunk by chunk against a queue
  // of expected {last, idx, data} built directly from the register array.
  task automatic dump1(input int rdy_pct, input int ack_delay, input int abort_at,
                       input string tag, output int first_valid, output int busy_fall);
    logic [13:0] exp_q[$];
    logic [13:0] prev, cur;
    bit prev_stall, last_acc, aborted, done;
    int got, stab_bad, pre_bad;
    first_valid = -1; busy_fall = -1;
    prev_stall = 0; last_acc = 0; aborted = 0; done = 0;
    got = 0; stab_bad = 0; pre_bad = 0; prev = '0;
    for (int i = 0; i < NREGS; i++) begin
      for (int c = CHUNKS - 1; c >= 0; c--) begin
        logic [31:0] w;
        w = rf[i];
        exp_q.push_back({1'((i == NREGS - 1) && (c == 0)), 5'(i), w[c*8 +: 8]});
      end
    end
    @(negedge clk);
    mode = 1'b0; start = 1'b1; out_ready = 1'b0; abort = 1'b0; step = 1'b0;
    halt_ack = (ack_delay == 0);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= 3000 && !done; k++) begin
      cur = {out_last, out_idx, out_data};
      if (last_acc) begin
        check({tag, " halt_req drop after last"}, {halt_req, busy}, 2'b01);
        last_acc = 0;
      end
      if (k < ack_delay + 2 && (out_valid || rf_rd_addr != 5'd0)) pre_bad++;
      if (ack_delay > 0) halt_ack = (k == ack_delay);
      if (out_valid && first_valid < 0) first_valid = k;
      if (!busy) begin
        busy_fall = k;
        done = 1;
      end else begin
        if (prev_stall && (!out_valid || cur !== prev)) stab_bad++;
        out_ready = ($urandom_range(0, 99) < rdy_pct);
        prev_stall = out_valid && !out_ready;
        prev = cur;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check({tag, " extra chunk"}, 1, 0);
          else check($sformatf("%s chunk %0d", tag, got), cur, exp_q.pop_front());
          if (got == abort_at) begin
            aborted = 1;
            abort = 1'b1;
          end
          got++;
          last_acc = out_last && !aborted;
        end
        @(negedge clk);
        if (aborted) begin
          check({tag, " outputs cleared"}, snap1(), 22'h0);
          abort = 1'b0;
          done = 1;
        end
      end
    end
    if (!done) check({tag, " timeout"}, 1, 0);
    out_ready = 1'b0;
    halt_ack = 1'b0;
    if (!aborted) begin
      check({tag, " chunks left"}, exp_q.size(), 0);
      check({tag, " stall stability"}, stab_bad, 0);
      check({tag, " quiet before ack"}, pre_bad, 0);
    end
  endtask

  task automatic dump2();
    logic [18:0] exp_q[$];
    logic [18:0] cur;
    bit done;
    int got;
    done = 0; got = 0;
    for (int i = 1; i < 4; i++) begin
      for (int c = 1; c >= 0; c--) begin
        logic [31:0] w;
        w = rf2[i];
        exp_q.push_back({1'((i == 3) && (c == 0)), 2'(i), w[c*16 +: 16]});
      end
    end
    @(negedge clk);
    mode2 = 1'b0; start2 = 1'b1; halt_ack2 = 1'b1;
    @(negedge clk);
    for (int k = 0; k <= 500 && !done; k++) begin
      start2 = (k == 5);
      if (!busy2) done = 1;
      else begin
        cur = {out_last2, out_idx2, out_data2};
        out_ready2 = ($urandom_range(0, 99) < 50);
        if (out_valid2 && out_ready2) begin
          if (exp_q.size() == 0) check("skip_x0 extra chunk", 1, 0);
          else check($sformatf("skip_x0 chunk %0d", got), cur, exp_q.pop_front());
          got++;
        end
        @(negedge clk);
      end
    end
    start2 = 1'b0; out_ready2 = 1'b0; halt_ack2 = 1'b0;
    check("skip_x0 finished", done, 1);
    check("skip_x0 chunk count", got, 6);
  endtask

  initial begin
    int fv, bf;
    start = 0; mode = 0; step = 0; abort = 0; halt_ack = 0; out_ready = 0;
    start2 = 0; mode2 = 0; step2 = 0; abort2 = 0; halt_ack2 = 0; out_ready2 = 0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    for (int i = 0; i < 4; i++) rf2[i] = $urandom;
    rf[0] = 32'hC0FFEE00;
    rf[1] = 32'hDEADBEEF;
    rf[2] = 32'h12345678;

    // Step-mode walk through x0..x2: stray step and a second start while halted are ignored,
    // each chunk needs its own step, stalls hold the chunk, then abort together with step.
    add(1, 1, 0, 0, 0, 0,  1, 1, 0, 5'd0, 8'h00, 0);
    add(1, 0, 1, 0, 0, 0,  1, 1, 0, 5'd0, 8'h00, 0);
    add(0, 0, 0, 1, 0, 0,  1, 1, 0, 5'd0, 8'h00, 0);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        logic [31:0] w;
        logic [7:0]  ch;
        w  = rf[r];
        ch = w[8*(3-c) +: 8];
        add(0, 0, 0, 0, 0, 0,  1, 1, 0, 5'(r), 8'h00, 0);
        add(0, 0, 1, 0, 0, 0,  1, 1, 1, 5'(r), ch, 1);
        add(0, 0, 1, 0, 0, 0,  1, 1, 1, 5'(r), ch, 1);
        add(0, 0, 0, 0, 1, 0,  1, 1, 0, (c == 3) ? 5'(r + 1) : 5'(r), 8'h00, 0);
      end
    end
    add(0, 0, 1, 0, 0, 1,  0, 0, 0, 5'd0, 8'h00, 1);

    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset state dut", snap1(), 22'h0);
    check("reset state dut2", snap2(), 24'h0);
    resetn = 1'b1;
    @(negedge clk);
    check("idle after reset", snap1(), 22'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      start = tbl[i].start; mode = tbl[i].mode; step = tbl[i].step;
      halt_ack = tbl[i].ack; out_ready = tbl[i].rdy; abort = tbl[i].abrt;
      @(posedge clk);
      #1;
      check($sformatf("step vec %0d", i),
            {busy, halt_req, out_valid, out_last, out_idx, rf_rd_addr,
             tbl[i].chk_data ? out_data : 8'h00},
            {tbl[i].e_busy, tbl[i].e_halt, tbl[i].e_valid, 1'b0, tbl[i].e_idx, tbl[i].e_idx,
             tbl[i].chk_data ? tbl[i].e_data : 8'h00});
    end
    @(negedge clk);
    start = 0; mode = 0; step = 0; abort = 0; halt_ack = 0; out_ready = 0;

    dump1(100, 0, -1, "stream", fv, bf);
    check("stream first valid", fv, 2);
    check("stream duration", bf, 162);

    dump1(60, 0, -1, "backpressure", fv, bf);

    dump1(100, 10, -1, "late ack", fv, bf);
    check("late ack first valid", fv, 12);
    check("late ack duration", bf, 172);

    dump1(100, 0, 22, "abort", fv, bf);
    dump1(100, 0, -1, "after abort", fv, bf);

    // Asynchronous reset in the middle of a streaming dump.
    @(negedge clk);
    halt_ack = 1'b1; out_ready = 1'b1; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    check("busy before reset", {busy, out_valid}, 2'b11);
    resetn = 1'b0;
    #1;
    check("reset mid-dump", snap1(), 22'h0);
    @(negedge clk);
    halt_ack = 1'b0; out_ready = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    check("idle after mid reset", snap1(), 22'h0);

    dump1(70, 3, -1, "after reset", fv, bf);

    dump2();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
